// File: rtl/psram_arb_pkg.sv
// Shared types and constants for the PSRAM requester arbiter.
package psram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] RD_ERR_DATA = 32'hFFFF_FFFF;
  localparam int          TIMEOUT_DEF = 1023;

endpackage

// File: rtl/psram_arb_rr_pick.sv
// Round-robin winner select: search starts one past the last grant.
module rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         idx,
  output logic               any
);

  always_comb begin
    gnt = '0;
    idx = last;
    any = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any && req[i] &&
            i == (int'(last) + off) % NUM_REQ) begin
          any    = 1'b1;
          gnt[i] = 1'b1;
          idx    = 2'(i);
        end
      end
    end
  end

endmodule

// File: rtl/psram_arb.sv
// Multi-requester arbiter in front of a single PSRAM controller port,
// with one outstanding transaction and a BUSY timeout abort.
module psram_arb
  import psram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*32-1:0] req_wdata_i,
  input  logic [NUM_REQ*4-1:0]  req_wstrb_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic [31:0]           req_rdata_o,
  output logic                  mem_valid_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_wstrb_o,
  input  logic                  mem_ready_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  mem_abort_o,
  output logic                  err_o,
  output logic [1:0]            err_id_o,
  input  logic                  err_clr_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t               state_q, state_d;
  logic [1:0]           last_q;
  logic [1:0]           win_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [31:0]          wdata_q;
  logic [3:0]           wstrb_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [31:0]          rdata_q;
  logic                 err_q;
  logic [1:0]           err_id_q;
  logic                 abort_q;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [1:0]           pick_idx;
  logic                 pick_any;
  logic                 take;
  logic                 done_ok;
  logic                 tmo;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req  (req_valid_i),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign take    = (state_q == IDLE) && pick_any;
  assign done_ok = (state_q == BUSY) && mem_ready_i;
  // A ready in the last allowed cycle wins over the timeout.
  assign tmo     = (state_q == BUSY) && !mem_ready_i &&
                   (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_any) state_d = BUSY;
      BUSY:    if (done_ok || tmo) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      last_q   <= 2'(NUM_REQ - 1);
      win_q    <= '0;
      gnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      err_id_q <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= tmo;
      if (take) begin
        win_q   <= pick_idx;
        gnt_q   <= pick_gnt;
        addr_q  <= req_addr_i[pick_idx*ADDR_W +: ADDR_W];
        wdata_q <= req_wdata_i[pick_idx*32 +: 32];
        wstrb_q <= req_wstrb_i[pick_idx*4 +: 4];
        cnt_q   <= '0;
      end else if (state_q == BUSY &&
                   cnt_q != CNT_W'(TIMEOUT)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (done_ok) begin
        rdata_q <= mem_rdata_i;
        last_q  <= win_q;
      end
      if (tmo) begin
        rdata_q  <= RD_ERR_DATA;
        last_q   <= win_q;
        err_id_q <= win_q;
      end
      if (tmo) begin
        err_q <= 1'b1;
      end else if (err_clr_i) begin
        err_q <= 1'b0;
      end
    end
  end

  assign mem_valid_o = (state_q == BUSY);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;
  assign req_ready_o = (state_q == DONE) ? gnt_q : '0;
  assign req_rdata_o = rdata_q;
  assign mem_abort_o = abort_q;
  assign err_o       = err_q;
  assign err_id_o    = err_id_q;

endmodule

// File: tb/tb_psram_arb.sv
// Scoreboard bench for psram_arb: directed transactions, a PSRAM
// responder model and a monitor that checks every ready pulse.
module tb_psram_arb;

  localparam int NR = 2;
  localparam int AW = 24;
  localparam int TO = 8;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] rdata;
    logic        err;
    logic        abort;
  } sb_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
  } mx_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*32-1:0]  req_wdata;
  logic [NR*4-1:0]   req_wstrb;
  logic [NR-1:0]     req_ready;
  logic [31:0]       req_rdata;
  logic              mem_valid;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic              mem_abort;
  logic              err;
  logic [1:0]        err_id;
  logic              err_clr;

  int  checks = 0;
  int  fails  = 0;
  int  cyc    = 0;
  int  ready_at = 0;
  int  bcnt   = 0;
  int  last_b = 0;
  sb_t sb[$];
  mx_t mq[$];
  mx_t cur;

  psram_arb #(
    .NUM_REQ(NR),
    .ADDR_W (AW),
    .TIMEOUT(TO)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .req_valid_i(req_valid),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .req_wstrb_i(req_wstrb),
    .req_ready_o(req_ready),
    .req_rdata_o(req_rdata),
    .mem_valid_o(mem_valid),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_wstrb_o(mem_wstrb),
    .mem_ready_i(mem_ready),
    .mem_rdata_i(mem_rdata),
    .mem_abort_o(mem_abort),
    .err_o      (err),
    .err_id_o   (err_id),
    .err_clr_i  (err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_of(input logic [AW-1:0] a);
    if (a == 24'h000100) return 32'hDEAD_BEEF;
    return {8'hA5, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_addr[k*AW +: AW] = a;
    req_wdata[k*32 +: 32] = d;
    req_wstrb[k*4 +: 4]   = s;
  endtask

  task automatic push(input logic [1:0] k, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] rd, input logic e);
    sb_t x;
    mx_t m;
    x.idx = k; x.rdata = rd; x.err = e; x.abort = e;
    m.addr = a; m.wdata = d; m.wstrb = s;
    sb.push_back(x);
    mq.push_back(m);
  endtask

  task automatic wait_ready(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        at = cyc;
        return;
      end
    end
    checks++;
    fails++;
    $display("FAIL ready_wait: no ready pulse within %0d cycles", budget);
  endtask

  // PSRAM model: answers on the ready_at-th BUSY cycle (0 = never).
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_valid) begin
        bcnt++;
        if (bcnt == 1) begin
          if (mq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL mem_unexpected: addr %h", mem_addr);
          end else begin
            cur = mq.pop_front();
          end
        end
        chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
        chk("mem_wdata", mem_wdata, cur.wdata);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
        mem_ready = (ready_at != 0) && (bcnt == ready_at);
        mem_rdata = mem_ready ? rd_of(cur.addr) : 32'h0BAD_0BAD;
      end else begin
        if (bcnt != 0) last_b = bcnt;
        bcnt = 0;
        mem_ready = 1'b0;
      end
    end
  end

  // Monitor: every ready pulse must match the oldest expectation.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (rst_n && req_ready != '0) begin
        chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        if (sb.size() == 0) begin
          chk("unexpected_ready", 32'(req_ready), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ready_idx", 32'(req_ready), 32'(1) << e.idx);
          chk("rdata", req_rdata, e.rdata);
          chk("err", 32'(err), 32'(e.err));
          chk("abort", 32'(mem_abort), 32'(e.abort));
          chk("mem_valid_done", 32'(mem_valid), 32'd0);
          if (e.err) chk("err_id", 32'(err_id), 32'(e.idx));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int at;
    int c0;
    rst_n = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_wdata = '0;
    req_wstrb = '0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rdata", req_rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_abort", 32'(mem_abort), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention: both held valid, grants must alternate 0,1,0,1.
    ready_at = 1;
    for (int n = 0; n < 4; n++) begin
      if (n % 2 == 0) push(2'd0, 24'h000200, 32'h0, 4'h0, rd_of(24'h000200), 1'b0);
      else            push(2'd1, 24'h000300, 32'h0, 4'h0, rd_of(24'h000300), 1'b0);
    end
    set_req(0, 24'h000200, 32'h0, 4'h0);
    set_req(1, 24'h000300, 32'h0, 4'h0);
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) wait_ready(20, at);
    req_valid = '0;
    @(negedge clk);

    // Single read and its latency.
    ready_at = 1;
    push(2'd0, 24'h000100, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    set_req(0, 24'h000100, 32'h0, 4'h0);
    req_valid = 2'b01;
    c0 = cyc;
    @(negedge clk);
    chk("mem_valid_plus1", 32'(mem_valid), 32'd1);
    wait_ready(20, at);
    chk("req_to_ready_cycles", 32'(at - c0 + 1), 32'd3);
    req_valid = '0;
    @(negedge clk);

    // Write whose requester drops valid and changes its bus mid-BUSY.
    ready_at = 3;
    push(2'd1, 24'h00FFFC, 32'h1234_5678, 4'hF, rd_of(24'h00FFFC), 1'b0);
    set_req(1, 24'h00FFFC, 32'h1234_5678, 4'hF);
    req_valid = 2'b10;
    @(negedge clk);
    req_valid = '0;
    set_req(1, 24'h555555, 32'hCAFE_F00D, 4'h3);
    wait_ready(20, at);
    @(negedge clk);

    // Timeout on requester 1, then clear the sticky flag.
    ready_at = 0;
    push(2'd1, 24'h000400, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b1);
    set_req(1, 24'h000400, 32'h0, 4'h0);
    req_valid = 2'b10;
    wait_ready(40, at);
    req_valid = '0;
    @(negedge clk);
    chk("tmo_busy_cycles", 32'(last_b), 32'd8);
    chk("err_sticky", 32'(err), 32'd1);
    chk("abort_one_cycle", 32'(mem_abort), 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);

    // Ready coincident with the timeout cycle completes normally.
    ready_at = 8;
    push(2'd0, 24'h000500, 32'h0, 4'h0, rd_of(24'h000500), 1'b0);
    set_req(0, 24'h000500, 32'h0, 4'h0);
    req_valid = 2'b01;
    wait_ready(40, at);
    req_valid = '0;
    @(negedge clk);
    chk("edge_busy_cycles", 32'(last_b), 32'd8);
    chk("edge_err", 32'(err), 32'd0);

    // Reset in the middle of a BUSY transaction.
    ready_at = 0;
    mq.push_back('{addr: 24'h000600, wdata: 32'h0, wstrb: 4'h0});
    set_req(1, 24'h000600, 32'h0, 4'h0);
    req_valid = 2'b10;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(mem_valid), 32'd1);
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    chk("arst_mem_valid", 32'(mem_valid), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_rdata", req_rdata, 32'd0);
    chk("arst_abort", 32'(mem_abort), 32'd0);
    chk("arst_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ready_at = 1;
    push(2'd0, 24'h000700, 32'h0, 4'h0, rd_of(24'h000700), 1'b0);
    set_req(0, 24'h000700, 32'h0, 4'h0);
    set_req(1, 24'h000800, 32'h0, 4'h0);
    req_valid = 2'b11;
    wait_ready(20, at);
    req_valid = '0;
    repeat (4) @(negedge clk);
    chk("sb_left", 32'(sb.size()), 32'd0);
    chk("mq_left", 32'(mq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
